// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
// Shared helpers for both pointer controllers of the asynchronous FIFO.
// Holds the pointer-width derivation and the Gray/binary conversions used on
// each side of the clock-domain crossing.
//
// The conversion functions work on a fixed 32-bit container. A narrower pointer
// is zero-extended on the way in, and the result is size-cast back by the
// caller. Zero upper bits stay zero through both conversions, so the low PW
// bits are exact for any pointer width up to 32.
// ---------------------------------------------------------------------------
package fifo_pkg;

   localparam int MAX_PW = 32;

   // The pointer carries one bit more than the RAM address. The extra bit
   // tells "full" apart from "empty" when the address bits are equal.
   function automatic int ptr_width(input int addr_w);
      return addr_w + 1;
   endfunction

   // Binary to reflected Gray: adjacent counts differ in exactly one bit.
   function automatic logic [MAX_PW-1:0] bin2gray(input logic [MAX_PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: an XOR chain that runs from the MSB down.
   function automatic logic [MAX_PW-1:0] gray2bin(input logic [MAX_PW-1:0] g);
      logic [MAX_PW-1:0] b;
      b[MAX_PW-1] = g[MAX_PW-1];
      for (int i = MAX_PW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Mask over the two MSBs of a Gray pointer. Both are inverted when
   // comparing against the opposite pointer to detect "full". The shift form
   // also works for the smallest pointer (pw = 2).
   function automatic logic [MAX_PW-1:0] full_mask(input int pw);
      return 32'd3 << (pw - 2);
   endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_ctrl_if
// Write-side bundle of the asynchronous FIFO. It connects the write pointer
// controller to its user, the RAM write port and the read-domain pointer.
//
// Signals (PW = ADDR_W + 1):
//   wr_en           write request from the producer
//   rptr_gray[PW]   Gray read pointer arriving from the read clock domain
//   wr_accept       qualified write, used as the RAM write enable
//   waddr[ADDR_W]   RAM write address
//   wptr_gray[PW]   registered Gray write pointer sent to the read domain
//   wr_full         registered full flag
//   wr_ovf          one-cycle pulse for a write dropped while full
//   wr_level[PW]    fill level (zero unless the level feature is built)
//   wr_almost_full  fill level at or above the threshold (same condition)
//
// Modports:
//   master  producer side: drives wr_en and rptr_gray, observes the rest
//   slave   the pointer controller
// ---------------------------------------------------------------------------
interface fifo_wr_ptr_ctrl_if
   import fifo_pkg::*;
#(
   parameter int ADDR_W = 4
);

   localparam int PW = ptr_width(ADDR_W);

   logic              wr_en;
   logic [PW-1:0]     rptr_gray;
   logic              wr_accept;
   logic [ADDR_W-1:0] waddr;
   logic [PW-1:0]     wptr_gray;
   logic              wr_full;
   logic              wr_ovf;
   logic [PW-1:0]     wr_level;
   logic              wr_almost_full;

   modport master (
      output wr_en,
      output rptr_gray,
      input  wr_accept,
      input  waddr,
      input  wptr_gray,
      input  wr_full,
      input  wr_ovf,
      input  wr_level,
      input  wr_almost_full
   );

   modport slave (
      input  wr_en,
      input  rptr_gray,
      output wr_accept,
      output waddr,
      output wptr_gray,
      output wr_full,
      output wr_ovf,
      output wr_level,
      output wr_almost_full
   );

endinterface

// File: rtl/fifo_wr_ptr_ctrl_sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a Gray-coded pointer. The pointer changes by at
// most one bit per source clock, so a bus-wide two-stage capture can only
// yield the old value or the new one, never a mix of the two.
// The read-side controller also uses this module for the write pointer.
//
// Ports:
//   clk      destination clock, rising edge
//   rst_n    synchronous active-low reset
//   d[W]     asynchronous Gray input
//   q[W]     synchronized output (second stage)
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q1;

   // The first stage may go metastable. The second stage gives it a full
   // clock period to settle before anything downstream sees the value.
   // Reset clears both stages so a fresh start compares against pointer zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q1 <= '0;
         q  <= '0;
      end else begin
         q1 <= d;
         q  <= q1;
      end
   end

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_wr_ptr_ctrl
// Write-side pointer controller of the asynchronous FIFO. Everything here
// runs in the write clock domain. The module:
//   - qualifies write requests against the full flag,
//   - advances the binary write pointer and exports it Gray-coded,
//   - brings the read domain's Gray pointer across a 2-flop synchronizer,
//   - raises full / overflow flags from the synchronized read pointer,
//   - optionally reports fill level and almost-full.
//
// Parameters:
//   ADDR_W     RAM address width (depth = 2**ADDR_W, pointer width ADDR_W+1)
//   AF_THRESH  almost-full asserts when the level is >= this value
//
// Ports:
//   wclk    write clock, rising edge
//   wrst_n  synchronous active-low reset
//   bus     fifo_wr_ptr_ctrl_if.slave (see interface header for signals)
//
// Build option:
//   FIFO_WR_LEVEL_EN  when defined, builds the fill-level and almost-full
//                     logic. When undefined, both outputs are tied to zero
//                     and no Gray-to-binary decode is built.
// ---------------------------------------------------------------------------
module fifo_wr_ptr_ctrl
   import fifo_pkg::*;
#(
   parameter int ADDR_W    = 4,
   parameter int AF_THRESH = 12
) (
   input logic              wclk,
   input logic              wrst_n,
   fifo_wr_ptr_ctrl_if.slave bus
);

   localparam int            PW        = ptr_width(ADDR_W);
   localparam logic [PW-1:0] FULL_MASK = PW'(full_mask(PW));

   logic [PW-1:0] wbin;
   logic [PW-1:0] wbin_nxt;
   logic [PW-1:0] wgray;
   logic [PW-1:0] wgray_nxt;
   logic [PW-1:0] rq2;
   logic          full_q;
   logic          ovf_q;
   logic          accept;

   // Bring the asynchronous read pointer into wclk. Only the second stage is
   // used, so a slot freed by the reader shows up here at least two write
   // clocks later. That delay errs on the safe side: the FIFO may look full
   // for a little longer, but it never accepts a write into a live slot.
   sync_2ff #(
      .W(PW)
   ) u_rptr_sync (
      .clk   (wclk),
      .rst_n (wrst_n),
      .d     (bus.rptr_gray),
      .q     (rq2)
   );

   // A write is accepted only when the registered full flag is low. Because
   // the flag is a flop, the RAM write enable never depends combinationally
   // on the asynchronous read pointer.
   // The next pointer wraps naturally modulo 2**PW, and its Gray form feeds
   // both the exported pointer and the full comparison.
   always_comb begin
      accept    = bus.wr_en & ~full_q;
      wbin_nxt  = wbin + PW'(accept);
      wgray_nxt = PW'(bin2gray(32'(wbin_nxt)));
   end

   // Pointer and flag registers. Full is evaluated against the next pointer,
   // so it rises on the same edge that stores the last free word.
   // In Gray code, "the writer is exactly one lap ahead" means the two MSBs
   // are inverted and the rest match.
   // Overflow records a request made while full; that write was refused and
   // its data is lost. Reset wins over any request in the same cycle.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         wbin   <= '0;
         wgray  <= '0;
         full_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         wbin   <= wbin_nxt;
         wgray  <= wgray_nxt;
         full_q <= (wgray_nxt == (rq2 ^ FULL_MASK));
         ovf_q  <= bus.wr_en & full_q;
      end
   end

`ifdef FIFO_WR_LEVEL_EN

   logic [PW-1:0] rbin;
   logic [PW-1:0] level_nxt;
   logic [PW-1:0] level_q;
   logic          af_q;

   localparam logic [PW-1:0] AF_LIM = PW'(AF_THRESH);

   // Decode the synchronized read pointer back to binary. The difference
   // from the next write pointer is the fill level. Modular subtraction keeps
   // it in 0..depth even after either pointer wraps.
   always_comb begin
      rbin      = PW'(gray2bin(32'(rq2)));
      level_nxt = wbin_nxt - rbin;
   end

   // Level and almost-full are registered alongside the full flag. All three
   // change on the same edge and agree with each other.
   always_ff @(posedge wclk) begin
      if (!wrst_n) begin
         level_q <= '0;
         af_q    <= 1'b0;
      end else begin
         level_q <= level_nxt;
         af_q    <= (level_nxt >= AF_LIM);
      end
   end

   assign bus.wr_level       = level_q;
   assign bus.wr_almost_full = af_q;

`else

   // Without the level feature the ports still exist, so the interface stays
   // the same in every build. They read as constant zero.
   assign bus.wr_level       = '0;
   assign bus.wr_almost_full = 1'b0;

`endif

   // The RAM address is the low part of the binary pointer. The extra MSB only
   // matters for telling full apart from empty.
   assign bus.wr_accept = accept;
   assign bus.waddr     = wbin[ADDR_W-1:0];
   assign bus.wptr_gray = wgray;
   assign bus.wr_full   = full_q;
   assign bus.wr_ovf    = ovf_q;

endmodule
